// File: rtl/fetch_stage.sv
// fetch_stage: IF stage that owns the PC and fetches in order from imem over req/ready + rvalid.
// Returned words are queued with their PC+4 and presented to IF/ID, with redirect flush and stall hold.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    output logic [31:0] inst_out,
    output logic [31:0] pcplus4_out
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW+1:0] QD = (CW+2)'(QDEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   q_inst [QDEPTH];
    logic [31:0]   q_pc4 [QDEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] occ, inflight, drop;
    logic [CW+1:0] total;
    logic          accept, enq, pop;
    logic [31:0]   resp_pc4;

    assign total       = (CW+2)'(occ) + (CW+2)'(inflight) + (CW+2)'(drop);
    assign imem_req    = !reset && !redirect && (total < QD);
    assign imem_addr   = fetch_pc;
    assign accept      = imem_req && imem_ready;
    assign enq         = imem_rvalid && (drop == '0);
    assign valid_out   = occ != '0;
    assign pop         = valid_out && !stall;
    assign inst_out    = valid_out ? q_inst[rd_ptr] : '0;
    assign pcplus4_out = valid_out ? q_pc4[rd_ptr] : '0;
    // Responses return in order, so the oldest live request's PC+4 follows from fetch_pc and inflight.
    assign resp_pc4    = fetch_pc + 32'd4 - (32'(inflight) << 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            inflight <= '0;
            drop     <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            inflight <= '0;
            drop     <= drop + inflight - CW'(imem_rvalid);
        end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            occ      <= occ + CW'(enq) - CW'(pop);
            inflight <= inflight + CW'(accept) - CW'(enq);
            drop     <= drop - CW'(imem_rvalid && (drop != '0));
        end
    end

    always_ff @(posedge clk) begin
        if (!redirect && enq) begin
            q_inst[wr_ptr] <= imem_rdata;
            q_pc4[wr_ptr]  <= resp_pc4;
        end
    end

    assert property (@(posedge clk) disable iff (reset) total <= QD);
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table plus scoreboarded sequences for fetch_stage against a latency-modelled imem.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, stall, redirect, imem_ready, imem_rvalid;
    logic        imem_req, valid_out;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, inst_out, pcplus4_out;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .valid_out(valid_out), .inst_out(inst_out), .pcplus4_out(pcplus4_out)
    );

    typedef struct { logic [31:0] inst; logic [31:0] pc4; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct {
        logic s; logic r; logic rdy;
        logic req; logic [31:0] addr; logic valid; logic [31:0] pc4;
    } vec_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    int    tests = 0, fails = 0, cycle = 0, lat = 1;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_inst, s_pc4, held;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cycle);
        end
    endtask

    // One cycle: drive at negedge, sample 1ns later, update the scoreboard, advance to next negedge.
    task automatic cyc(input logic s, input logic r, input logic [31:0] rpc, input logic rdy);
        exp_t e;
        stall = s; redirect = r; redirect_pc = rpc; imem_ready = rdy;
        if (pend_q.size() > 0 && pend_q[0].due <= cycle) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(pend_q[0].addr);
            void'(pend_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hBAD0_BAD0;
        end
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = valid_out; s_inst = inst_out; s_pc4 = pcplus4_out;
        if (!s_valid) begin
            check("bubble_inst", s_inst, 32'h0);
            check("bubble_pc4", s_pc4, 32'h0);
        end
        if (r) begin
            check("req_on_redirect", 32'(s_req), 32'h0);
            exp_q.delete();
        end else if (s_valid && !s) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL pop_underflow: got pc4 %h expected no valid output", s_pc4);
            end else begin
                e = exp_q.pop_front();
                check("pop_inst", s_inst, e.inst);
                check("pop_pc4", s_pc4, e.pc4);
            end
        end
        if (s_req && rdy) begin
            pend_q.push_back('{s_addr, cycle + lat});
            exp_q.push_back('{memf(s_addr), s_addr + 32'd4});
        end
        @(negedge clk);
        cycle++;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        pend_q.delete(); exp_q.delete();
        #1;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_inst", inst_out, 32'h0);
        check("rst_pc4", pcplus4_out, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cycle = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (pend_q.size() == 0 && exp_q.size() == 0) break;
            cyc(1'b0, 1'b0, 32'h0, 1'b0);
        end
        check("drain_left", 32'(exp_q.size()), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("drain_valid", 32'(s_valid), 32'h0);
    endtask

    task automatic wait_valid(input logic rdy);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0, 32'h0, rdy);
            if (s_valid) break;
        end
    endtask

    vec_t tv[8];

    initial begin
        tv[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        tv[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
        tv[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd8,  1'b1, 32'd4};
        tv[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 32'd8};
        tv[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd12, 1'b0, 32'd0};
        tv[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd16, 1'b1, 32'd12};
        tv[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd16};
        tv[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd20, 1'b0, 32'd0};

        // Streaming from reset, 1-cycle memory latency
        lat = 1;
        do_reset();
        foreach (tv[k]) begin
            cyc(tv[k].s, tv[k].r, 32'h0, tv[k].rdy);
            check($sformatf("vec%0d_req", k), 32'(s_req), 32'(tv[k].req));
            check($sformatf("vec%0d_addr", k), s_addr, tv[k].addr);
            check($sformatf("vec%0d_valid", k), 32'(s_valid), 32'(tv[k].valid));
            check($sformatf("vec%0d_pc4", k), s_pc4, tv[k].pc4);
        end
        drain();

        // Stall holds the head and exhausts credit
        do_reset();
        wait_valid(1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        held = s_pc4;
        check("stall_valid0", 32'(s_valid), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1);
            check("stall_head", s_pc4, held);
            check("stall_valid", 32'(s_valid), 32'h1);
        end
        check("stall_req_off", 32'(s_req), 32'h0);
        repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        drain();

        // Redirect with two requests in flight
        lat = 2;
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b1, 32'h100, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_addr", s_addr, 32'h100);
        check("redir_req", 32'(s_req), 32'h1);
        wait_valid(1'b1);
        check("redir_first_valid", 32'(s_valid), 32'h1);
        check("redir_first_pc4", s_pc4, 32'h104);
        drain();

        // Unaligned redirect while stalled still flushes the queue
        lat = 1;
        do_reset();
        wait_valid(1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b1, 32'h103, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("flush_valid", 32'(s_valid), 32'h0);
        check("flush_addr", s_addr, 32'h100);
        wait_valid(1'b1);
        check("flush_first_pc4", s_pc4, 32'h104);
        drain();

        // imem backpressure and 3-cycle latency
        lat = 3;
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("credit_req_off", 32'(s_req), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0);
            check("notready_addr", s_addr, 32'h8);
        end
        repeat (8) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        drain();

        // Asynchronous reset with a full queue
        lat = 1;
        do_reset();
        wait_valid(1'b1);
        repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("full_valid", 32'(s_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async_valid", 32'(valid_out), 32'h0);
        check("async_inst", inst_out, 32'h0);
        check("async_pc4", pcplus4_out, 32'h0);
        check("async_req", 32'(imem_req), 32'h0);
        check("async_addr", imem_addr, 32'h0);
        stall = 1'b0; imem_ready = 1'b0;
        pend_q.delete(); exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        cycle = 0;
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("restart_addr", s_addr, 32'h0);
        check("restart_req", 32'(s_req), 32'h1);
        repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
